// File: rtl/vivado_top_pkg.sv
// Shared definitions for vivado_top: FSM state encoding, loop-bound formation
// and the active-low seven-segment glyph table.
package vivado_top_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic [7:0] form_n(input logic [3:0] sw);
    return {sw, 4'hF};
  endfunction

  // Cathode order {dp,g,f,e,d,c,b,a}, active-low, dp always off.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0:    g = 8'hC0;
      4'h1:    g = 8'hF9;
      4'h2:    g = 8'hA4;
      4'h3:    g = 8'hB0;
      4'h4:    g = 8'h99;
      4'h5:    g = 8'h92;
      4'h6:    g = 8'h82;
      4'h7:    g = 8'hF8;
      4'h8:    g = 8'h80;
      4'h9:    g = 8'h90;
      4'hA:    g = 8'h88;
      4'hB:    g = 8'h83;
      4'hC:    g = 8'hC6;
      4'hD:    g = 8'hA1;
      4'hE:    g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/vivado_top_seg_mux.sv
// Four-digit multiplexed seven-segment driver: a free-running refresh counter
// selects the digit, the selected nibble is decoded to active-low cathodes.
module seg_mux
  import vivado_top_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  output logic [11:0] seg
);

  localparam int unsigned W = REFRESH_BITS + 2;

  logic [W-1:0] refresh;
  logic [1:0]   digit;
  logic [3:0]   nib;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) refresh <= '0;
    else        refresh <= refresh + W'(1);
  end

  assign digit = refresh[W-1:W-2];

  always_comb begin
    nib = value[3:0];
    case (digit)
      2'd0: nib = value[3:0];
      2'd1: nib = value[7:4];
      2'd2: nib = value[11:8];
      2'd3: nib = value[15:12];
      default: nib = value[3:0];
    endcase
    seg = {~(4'b0001 << digit), hex_glyph(nib)};
  end

endmodule

// File: rtl/vivado_top.sv
// Sums 0..N (N = {sw,4'hF}) with a three-state FSM, shows the result or {N,i}
// on a multiplexed seven-segment display, and reports status on LEDs.
module vivado_top
  import vivado_top_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  sw,
  input  logic [1:0]  btn,
  output logic [11:0] seg,
  output logic        finish,
  output logic [12:0] leds
);

  state_t      state, state_next;
  logic [15:0] acc;
  logic [7:0]  i;
  logic [7:0]  n;
  logic [1:0]  btn_meta, btn_sync;
  logic        b0_prev;
  logic        restart;
  logic [15:0] disp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
      b0_prev  <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      b0_prev  <= btn_sync[0];
    end
  end

  assign restart = btn_sync[0] & ~b0_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     if (i == n) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // A restart edge suppresses the datapath step so RUN never advances on it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      i   <= '0;
      n   <= '0;
    end else if (!restart) begin
      case (state)
        IDLE: begin
          acc <= '0;
          i   <= '0;
          n   <= form_n(sw);
        end
        RUN: begin
          acc <= acc + {8'd0, i};
          if (i != n) i <= i + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign finish = (state == DONE);
  assign leds   = {state, btn_sync[1], finish, state == RUN, i};
  assign disp   = btn_sync[1] ? {n, i} : acc;

  seg_mux #(.REFRESH_BITS(REFRESH_BITS)) u_seg_mux (
    .clk   (clk),
    .reset (reset),
    .value (disp),
    .seg   (seg)
  );

endmodule

// File: tb/tb_vivado_top.sv
// Randomized bench for vivado_top with an elapsed-time behavioural model,
// a per-cycle compare process and hand-computed directed expectations.
module tb_vivado_top;

  localparam int RB = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  sw = 4'h0;
  logic [1:0]  btn = 2'b00;
  logic [11:0] seg;
  logic        finish;
  logic [12:0] leds;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  vivado_top #(.REFRESH_BITS(RB)) dut (
    .clk    (clk),
    .reset  (reset),
    .sw     (sw),
    .btn    (btn),
    .seg    (seg),
    .finish (finish),
    .leds   (leds)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: computation described by time elapsed since RUN was entered.
  bit         m_idle = 1'b1;
  int         m_el = 0;
  logic [7:0] m_n = '0;
  logic [1:0] mmeta = '0, msync = '0;
  bit         mprev0 = 1'b0;
  int         mref = 0;

  always @(posedge clk or negedge reset) begin
    bit rst_edge;
    if (!reset) begin
      m_idle = 1'b1; m_el = 0; m_n = '0;
      mmeta = '0; msync = '0; mprev0 = 1'b0; mref = 0;
    end else begin
      rst_edge = msync[0] && !mprev0;
      mprev0 = msync[0];
      msync = mmeta;
      mmeta = btn;
      mref++;
      if (rst_edge) m_idle = 1'b1;
      else if (m_idle) begin
        m_idle = 1'b0;
        m_n = {sw, 4'hF};
        m_el = 0;
      end else if (m_el < 400) m_el++;
    end
  end

  always @(negedge clk) begin
    int m, ei, ea, es, dg;
    logic [15:0] ev;
    logic [11:0] eseg;
    logic [12:0] el;
    if (chk_en) begin
      m  = (m_el < int'(m_n) + 1) ? m_el : int'(m_n) + 1;
      ea = m * (m - 1) / 2;
      ei = (m_el < int'(m_n)) ? m_el : int'(m_n);
      es = m_idle ? 0 : ((m_el > int'(m_n)) ? 2 : 1);
      ev = msync[1] ? {m_n, 8'(ei)} : 16'(ea);
      dg = (mref >> RB) % 4;
      eseg = {~(4'(1 << dg)), glyph(4'(ev >> (4 * dg)))};
      el = {2'(es), msync[1], es == 2, es == 1, 8'(ei)};
      check("seg", 32'(seg), 32'(eseg));
      check("leds", 32'(leds), 32'(el));
      check("finish", 32'(finish), 32'(es == 2));
    end
  end

  task automatic wait_finish(input int limit, output int edges);
    edges = 0;
    while (edges < limit) begin
      @(posedge clk); #1;
      edges++;
      if (finish) return;
    end
    total++; bad++;
    $display("FAIL finish_timeout: got no finish expected finish within %0d edges", limit);
  endtask

  task automatic read_display(output logic [15:0] v);
    v = '0;
    repeat (4 << RB) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++)
        if (!seg[8 + k])
          for (int g = 0; g < 16; g++)
            if (glyph(4'(g)) == seg[7:0]) v[4 * k +: 4] = 4'(g);
    end
  endtask

  task automatic scan_check();
    int prev, run, idx, lows;
    bit started;
    prev = -1; run = 0; started = 1'b0;
    repeat (12 << RB) begin
      @(posedge clk); #1;
      lows = 0; idx = -1;
      for (int k = 0; k < 4; k++)
        if (!seg[8 + k]) begin lows++; idx = k; end
      check("anode_count", 32'(lows), 32'd1);
      if (idx != prev) begin
        if (started) check("scan_len", 32'(run), 32'(1 << RB));
        if (prev >= 0) begin
          check("scan_order", 32'(idx), 32'((prev + 1) % 4));
          started = 1'b1;
        end
        prev = idx; run = 1;
      end else run++;
    end
  endtask

  initial begin
    int edges, drop;
    logic [15:0] v;
    #2 reset = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset_seg", 32'(seg), 32'h0EC0);
    check("reset_leds", 32'(leds), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_finish(100, edges);
    check("n15_finish_edge", 32'(edges), 32'd17);
    read_display(v);
    check("n15_acc", 32'(v), 32'h0078);
    scan_check();

    @(negedge clk); btn[1] = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("btn1_led", 32'(leds[10]), 32'd1);
    read_display(v);
    check("btn1_disp", 32'(v), 32'h0F0F);
    @(negedge clk); btn[1] = 1'b0;
    repeat (3) @(negedge clk);

    sw = 4'hF;
    #2 reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    wait_finish(400, edges);
    check("n255_finish_edge", 32'(edges), 32'd257);
    check("n255_i", 32'(leds[7:0]), 32'hFF);
    read_display(v);
    check("n255_acc", 32'(v), 32'h7F80);

    @(negedge clk); sw = 4'h1; btn[0] = 1'b1;
    drop = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk); #1;
      if (!finish && drop == 0) drop = cyc;
      @(negedge clk);
      if (cyc == 3) btn[0] = 1'b0;
    end
    check("restart_drop", 32'(drop), 32'd3);
    wait_finish(200, edges);
    read_display(v);
    check("n31_acc", 32'(v), 32'h01F0);

    @(negedge clk); sw = 4'h2; btn[0] = 1'b1;
    repeat (2) @(negedge clk);
    btn[0] = 1'b0;
    repeat (15) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrun_finish", 32'(finish), 32'd0);
    check("midrun_leds", 32'(leds), 32'h0);
    check("midrun_seg", 32'(seg), 32'h0EC0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_finish(200, edges);
    check("n47_finish_edge", 32'(edges), 32'd49);
    read_display(v);
    check("n47_acc", 32'(v), 32'h0468);

    for (int it = 0; it < 40; it++) begin
      int act;
      @(negedge clk);
      sw = 4'($urandom);
      btn[1] = 1'($urandom_range(0, 1));
      act = $urandom_range(0, 9);
      if (act == 0) begin
        #3 reset = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b1;
      end else if (act < 4) begin
        btn[0] = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        btn[0] = 1'b0;
      end
      repeat ($urandom_range(1, 300)) @(negedge clk);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
